// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment encoder: segment vector type,
// blank pattern, the 16-entry digit table and the settle FSM state enum.
package seg_pkg;

  // Index 0 is segment a, index 6 is segment g; active-low (0 = lit).
  typedef logic [0:6] seg_t;

  typedef enum logic {StIdle, StSettle} state_e;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg_to_hex.sv
// Combinational lookup: segment pattern -> hex digit, with an error flag when the
// pattern is not one of the 16 table entries (digit forced to 0 in that case).
module seg_to_hex
  import seg_pkg::*;
(
  input  seg_t        i_seg,
  output logic [3:0]  o_hex,
  output logic        o_err
);

  always_comb begin
    o_hex = 4'h0;
    o_err = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG_TABLE[i]) begin
        o_hex = 4'(i);
        o_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_seg_encoder.sv
// Debounced seven-segment to hex encoder with valid/ready output and sticky overrun.
// Optional SEG_ERR_COUNT_EN adds a saturating err_count output.
module seven_seg_encoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  seg_t        seg_in,
  output logic [3:0]  hex_out,
  output logic        seg_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  input  logic        clr_overrun
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

  state_e     r_state;
  state_e     w_state_next;
  seg_t       r_seg;
  logic [7:0] r_cnt;
  logic [3:0] r_hex;
  logic       r_err;
  logic       r_valid;
  logic       r_overrun;

  logic       w_changed;
  logic       w_commit;
  logic       w_emit;
  logic       w_accept;
  logic       w_load;
  logic       w_drop;
  logic [3:0] w_lut_hex;
  logic       w_lut_err;

  seg_to_hex u_seg_to_hex (
    .i_seg (r_seg),
    .o_hex (w_lut_hex),
    .o_err (w_lut_err)
  );

  assign w_changed = (seg_in != r_seg);

  // State register
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: any change restarts settling, from either state.
  always_comb begin
    w_state_next = r_state;
    if (w_changed) begin
      w_state_next = StSettle;
    end else if (w_commit) begin
      w_state_next = StIdle;
    end
  end

  // Output / control decode
  always_comb begin
    w_commit = (r_state == StSettle) && !w_changed && (r_cnt == CntMax);
    w_emit   = w_commit && (r_seg != SEG_BLANK);
    w_accept = r_valid && out_ready;
    w_load   = w_emit && (!r_valid || out_ready);
    w_drop   = w_emit && r_valid && !out_ready;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_seg <= SEG_BLANK;
      r_cnt <= 8'd0;
    end else if (w_changed) begin
      r_seg <= seg_in;
      r_cnt <= 8'd0;
    end else if (r_state == StSettle && !w_commit) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Result register: a simultaneous accept and commit reloads and keeps valid high.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_hex   <= 4'h0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_hex   <= w_lut_hex;
      r_err   <= w_lut_err;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  // Set has priority over clear.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef SEG_ERR_COUNT_EN
  logic [7:0] r_err_count;

  // Counts every error commit, dropped ones included.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_err_count <= 8'd0;
    end else if (w_emit && w_lut_err && r_err_count != 8'hFF) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign hex_out   = r_hex;
  assign seg_err   = r_err;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_seven_seg_encoder.sv
// Self-checking bench for seven_seg_encoder: vector table plus scoreboard of expected
// results, with hand-written sequences for latency, glitch, overrun and reset cases.
module tb_seven_seg_encoder;
  import seg_pkg::*;

  localparam int S = 4;

  logic       Clk = 1'b0;
  logic       ResetN = 1'b0;
  seg_t       seg_in = 7'b1111111;
  logic [3:0] hex_out;
  logic       seg_err;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       overrun;
  logic       clr_overrun = 1'b0;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0] err_count;
  int         exp_err_cnt = 0;
`endif

  seven_seg_encoder #(.STABLE_CYCLES(S)) dut (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .seg_in      (seg_in),
    .hex_out     (hex_out),
    .seg_err     (seg_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
`ifdef SEG_ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [0:6] seg;
    logic [3:0] hex;
    logic       err;
    logic       emit;
  } vec_t;

  typedef struct {
    logic [3:0] hex;
    logic       err;
  } exp_t;

  vec_t vecs [19];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] h, input logic e);
    exp_t x;
    x.hex = h;
    x.err = e;
    sb.push_back(x);
  endtask

  // Scoreboard: every accepted result must match the oldest expected entry.
  always @(negedge Clk) begin
    if (ResetN && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got hex %0h err %0b, expected none", hex_out, seg_err);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("sb_hex", int'(hex_out), int'(x.hex));
        check("sb_err", int'(seg_err), int'(x.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{7'b0000001, 4'h0, 1'b0, 1'b1};
    vecs[1]  = '{7'b1001111, 4'h1, 1'b0, 1'b1};
    vecs[2]  = '{7'b0010010, 4'h2, 1'b0, 1'b1};
    vecs[3]  = '{7'b0000110, 4'h3, 1'b0, 1'b1};
    vecs[4]  = '{7'b1001100, 4'h4, 1'b0, 1'b1};
    vecs[5]  = '{7'b0100100, 4'h5, 1'b0, 1'b1};
    vecs[6]  = '{7'b0100000, 4'h6, 1'b0, 1'b1};
    vecs[7]  = '{7'b0001111, 4'h7, 1'b0, 1'b1};
    vecs[8]  = '{7'b0000000, 4'h8, 1'b0, 1'b1};
    vecs[9]  = '{7'b0000100, 4'h9, 1'b0, 1'b1};
    vecs[10] = '{7'b0001000, 4'hA, 1'b0, 1'b1};
    vecs[11] = '{7'b1100000, 4'hB, 1'b0, 1'b1};
    vecs[12] = '{7'b0110001, 4'hC, 1'b0, 1'b1};
    vecs[13] = '{7'b1000010, 4'hD, 1'b0, 1'b1};
    vecs[14] = '{7'b0110000, 4'hE, 1'b0, 1'b1};
    vecs[15] = '{7'b0111000, 4'hF, 1'b0, 1'b1};
    vecs[16] = '{7'b1010101, 4'h0, 1'b1, 1'b1};
    vecs[17] = '{7'b1111111, 4'h0, 1'b0, 1'b0};
    vecs[18] = '{7'b0000000, 4'h8, 1'b0, 1'b1};

    // Reset state
    #3;
    check("rst_valid", int'(out_valid), 0);
    check("rst_hex", int'(hex_out), 0);
    check("rst_err", int'(seg_err), 0);
    check("rst_overrun", int'(overrun), 0);
    @(negedge Clk);
    ResetN = 1'b1;
    tick(2);

    // Latency and pulse width for digit 2
    seg_in = 7'b0010010;
    push(4'h2, 1'b0);
    tick(1);
    for (int i = 1; i < S; i++) begin
      tick(1);
      check("latency_early", int'(out_valid), 0);
    end
    tick(1);
    check("latency_valid", int'(out_valid), 1);
    check("latency_hex", int'(hex_out), 2);
    check("latency_err", int'(seg_err), 0);
    tick(1);
    check("pulse_end", int'(out_valid), 0);
    check("hold_hex", int'(hex_out), 2);
    tick(2);

    // Table sweep, error pattern, silent blank; holding longer checks no recommit
    for (int i = 0; i < 19; i++) begin
      seg_in = vecs[i].seg;
      if (vecs[i].emit) push(vecs[i].hex, vecs[i].err);
`ifdef SEG_ERR_COUNT_EN
      if (vecs[i].emit && vecs[i].err) exp_err_cnt++;
`endif
      tick(S + 4);
      check("sweep_overrun", int'(overrun), 0);
    end
`ifdef SEG_ERR_COUNT_EN
    check("err_count", int'(err_count), exp_err_cnt);
`endif

    // Glitch: short 3 is rejected, only E is produced
    seg_in = 7'b0000110;
    tick(2);
    seg_in = 7'b0110000;
    push(4'hE, 1'b0);
    tick(S + 4);

    // Overrun: 1 held unaccepted, B dropped
    out_ready = 1'b0;
    seg_in = 7'b1001111;
    push(4'h1, 1'b0);
    tick(S + 2);
    check("ovr_first_valid", int'(out_valid), 1);
    check("ovr_first_hex", int'(hex_out), 1);
    seg_in = 7'b1100000;
    tick(S + 2);
    check("ovr_hold_hex", int'(hex_out), 1);
    check("ovr_set", int'(overrun), 1);
    check("ovr_hold_valid", int'(out_valid), 1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check("ovr_clear", int'(overrun), 0);

    // Set wins over a simultaneous clear
    clr_overrun = 1'b1;
    seg_in = 7'b0000110;
    tick(S + 1);
    check("ovr_set_wins", int'(overrun), 1);
    clr_overrun = 1'b0;
    tick(1);
    check("ovr_sticky", int'(overrun), 1);
    check("ovr_hold_hex2", int'(hex_out), 1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    out_ready = 1'b1;
    tick(1);
    check("drain_valid", int'(out_valid), 0);
    tick(2);

    // Reset mid-settle with a held result and overrun set
    out_ready = 1'b0;
    seg_in = 7'b0001111;
    tick(S + 2);
    seg_in = 7'b0000000;
    tick(S + 2);
    check("pre_rst_overrun", int'(overrun), 1);
    seg_in = 7'b0001000;
    tick(2);
    #2;
    ResetN = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_hex", int'(hex_out), 0);
    check("async_rst_err", int'(seg_err), 0);
    check("async_rst_overrun", int'(overrun), 0);
`ifdef SEG_ERR_COUNT_EN
    exp_err_cnt = 0;
    check("async_rst_errcnt", int'(err_count), 0);
`endif
    out_ready = 1'b1;
    @(negedge Clk);
    ResetN = 1'b1;
    push(4'hA, 1'b0);
    tick(1);
    tick(S - 1);
    check("post_rst_early", int'(out_valid), 0);
    tick(1);
    check("post_rst_valid", int'(out_valid), 1);
    check("post_rst_hex", int'(hex_out), 4'hA);
    tick(4);

    check("scoreboard_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
